// File: rtl/branch_outcome_queue.sv
// In-order queue of predicted branches between fetch and execute; drives predictor update and redirect.
// Optional statistics counters are enabled by defining BOQ_STATS_EN.
module branch_outcome_queue #(
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = 3,
    parameter int PC_WIDTH  = 16,
    parameter int PC_INC    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc,
    input  logic [PC_WIDTH-1:0] allocPC,
    input  logic [PC_WIDTH-1:0] allocTarget,
    input  logic                allocG,
    input  logic                allocP,
    input  logic                allocPred,
    input  logic                resolve,
    input  logic                resolveTaken,
    input  logic                flush,
    output logic                full,
    output logic                empty,
    output logic [PTR_WIDTH:0]  count,
    output logic                update,
    output logic [PC_WIDTH-1:0] updatePC,
    output logic                gReality,
    output logic                pReality,
    output logic                reality,
    output logic                mispredict,
    output logic [PC_WIDTH-1:0] redirectPC,
    output logic                underflow,
    output logic [15:0]         resolvedCount,
    output logic [15:0]         mispredCount
);

    localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);

    logic [PC_WIDTH-1:0]  pc_mem  [DEPTH];
    logic [PC_WIDTH-1:0]  tgt_mem [DEPTH];
    logic [DEPTH-1:0]     g_mem;
    logic [DEPTH-1:0]     p_mem;
    logic [DEPTH-1:0]     pred_mem;

    logic [PTR_WIDTH-1:0] head;
    logic [PTR_WIDTH-1:0] tail;
    logic [PTR_WIDTH:0]   occ;

    logic                 res_acc;
    logic                 mis_now;
    logic                 alloc_acc;
    logic                 clear_all;

    function automatic logic [PC_WIDTH-1:0] next_pc(
        input logic [PC_WIDTH-1:0] pc,
        input logic [PC_WIDTH-1:0] tgt,
        input logic                taken
    );
        return taken ? tgt : pc + PC_WIDTH'(PC_INC);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign count = occ;
    assign full  = (occ == FULL_COUNT);
    assign empty = (occ == '0);

    // A mispredict squashes every younger entry, so an alloc in the same cycle is wrong-path too.
    assign res_acc   = resolve && !empty;
    assign mis_now   = res_acc && (pred_mem[head] != resolveTaken);
    assign clear_all = flush || mis_now;
    assign alloc_acc = alloc && (!full || res_acc) && !clear_all;

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (alloc_acc) begin
            pc_mem[tail]   <= allocPC;
            tgt_mem[tail]  <= allocTarget;
            g_mem[tail]    <= allocG;
            p_mem[tail]    <= allocP;
            pred_mem[tail] <= allocPred;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            occ       <= '0;
            underflow <= 1'b0;
        end else begin
            if (resolve && empty) underflow <= 1'b1;
            if (clear_all) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                if (res_acc)   head <= head + 1'b1;
                if (alloc_acc) tail <= tail + 1'b1;
                occ <= occ + (PTR_WIDTH+1)'(alloc_acc) - (PTR_WIDTH+1)'(res_acc);
            end
        end
    end

    // Registered predictor update / redirect; data fields hold between resolves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            update     <= 1'b0;
            mispredict <= 1'b0;
            updatePC   <= '0;
            redirectPC <= '0;
            gReality   <= 1'b0;
            pReality   <= 1'b0;
            reality    <= 1'b0;
        end else begin
            update     <= res_acc;
            mispredict <= mis_now;
            if (res_acc) begin
                updatePC   <= pc_mem[head];
                gReality   <= g_mem[head];
                pReality   <= p_mem[head];
                reality    <= resolveTaken;
                redirectPC <= next_pc(pc_mem[head], tgt_mem[head], resolveTaken);
            end
        end
    end

`ifdef BOQ_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resolvedCount <= '0;
            mispredCount  <= '0;
        end else begin
            if (res_acc) resolvedCount <= sat_inc(resolvedCount);
            if (mis_now) mispredCount  <= sat_inc(mispredCount);
        end
    end
`else
    assign resolvedCount = '0;
    assign mispredCount  = '0;
`endif

endmodule
